// File: rtl/fir_interp_poly_if.sv
// -----------------------------------------------------------------------------
// fir_interp_poly_if
//   Bundles the sample stream and coefficient-write signals of fir_interp_poly.
//
//   Handshake: a transfer happens on a rising clk edge where valid and ready
//   are both 1. A source holds valid and its data stable until that edge, and
//   valid never depends on ready in the same cycle.
//
//   Signals
//     in_valid / in_ready / in_data     : input sample stream (signed)
//     out_valid / out_ready / out_data  : output sample stream (signed)
//     coef_wr_en / coef_addr / coef_data: coefficient write port
//     coef_err                          : one-cycle pulse, write dropped (busy)
//
//   Modports
//     master : the side that feeds samples and coefficients (bench / upstream)
//     slave  : the filter
// -----------------------------------------------------------------------------
interface fir_interp_poly_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int COEFF_WIDTH = 8,
  parameter int NUM_TAPS    = 16
);
  localparam int AW = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;

  logic                          in_valid;
  logic                          in_ready;
  logic signed [DATA_WIDTH-1:0]  in_data;
  logic                          out_valid;
  logic                          out_ready;
  logic signed [DATA_WIDTH-1:0]  out_data;
  logic                          coef_wr_en;
  logic        [AW-1:0]          coef_addr;
  logic signed [COEFF_WIDTH-1:0] coef_data;
  logic                          coef_err;

  modport master (
    output in_valid, in_data, out_ready, coef_wr_en, coef_addr, coef_data,
    input  in_ready, out_valid, out_data, coef_err
  );

  modport slave (
    input  in_valid, in_data, out_ready, coef_wr_en, coef_addr, coef_data,
    output in_ready, out_valid, out_data, coef_err
  );
endinterface

// File: rtl/fir_interp_poly.sv
// -----------------------------------------------------------------------------
// fir_interp_poly
//   Polyphase interpolating FIR filter (factor INTERP). Each accepted input
//   sample produces INTERP output samples, phase 0 first. Phase p uses the
//   taps h[k*INTERP+p], k = 0..K-1, with K = NUM_TAPS/INTERP, against the
//   K-deep delay line x[0..K-1] (x[0] newest). A single multiplier is shared
//   over K cycles per phase.
//
//   FSM: IDLE -> ACCUM (K cycles) -> OUTPUT -> ACCUM (next phase) ... -> IDLE
//
//   Ports
//     clk     : clock, rising edge
//     rst     : asynchronous, active-high reset
//     bus     : fir_interp_poly_if.slave (sample streams + coefficient port)
//     state_o : current FSM state (debug)
//
//   Parameters
//     DATA_WIDTH, COEFF_WIDTH : signed sample / coefficient widths
//     NUM_TAPS, INTERP        : prototype length, interpolation factor
//     SHIFT                   : arithmetic right shift before saturation
//
//   Build option
//     FIR_INTERP_ROUND_EN : when defined, round half up before the shift
//                           (adds 2^(SHIFT-1)); otherwise plain truncation.
// -----------------------------------------------------------------------------
module fir_interp_poly #(
  parameter int DATA_WIDTH  = 8,
  parameter int COEFF_WIDTH = 8,
  parameter int NUM_TAPS    = 16,
  parameter int INTERP      = 2,
  parameter int SHIFT       = 0
) (
  input  logic             clk,
  input  logic             rst,
  fir_interp_poly_if.slave bus,
  output logic [1:0]       state_o
);

  localparam int K      = NUM_TAPS / INTERP;
  localparam int AW     = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam int KW     = (K > 1) ? $clog2(K) : 1;
  localparam int PW     = $clog2(INTERP);
  localparam int PROD_W = DATA_WIDTH + COEFF_WIDTH;
  localparam int ACC_W  = PROD_W + $clog2(K);
  // One spare bit so the rounding constant can never wrap the accumulator.
  localparam int EXT_W  = ACC_W + 1;

  localparam logic signed [EXT_W-1:0] SAT_MAX =
    EXT_W'((1 <<< (DATA_WIDTH - 1)) - 1);
  localparam logic signed [EXT_W-1:0] SAT_MIN =
    EXT_W'(-(1 <<< (DATA_WIDTH - 1)));

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCUM  = 2'd1;
  localparam logic [1:0] S_OUTPUT = 2'd2;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]                    state_q,    state_d;
  logic [PW-1:0]                 phase_q,    phase_d;
  logic [KW-1:0]                 k_q,        k_d;
  logic signed [ACC_W-1:0]       acc_q,      acc_d;
  logic signed [DATA_WIDTH-1:0]  out_data_q, out_data_d;
  logic                          coef_err_q;
  logic signed [DATA_WIDTH-1:0]  x_q [K];
  logic signed [COEFF_WIDTH-1:0] h_q [NUM_TAPS];

  logic                          idle;
  logic                          accept;
  logic                          coef_hit;
  logic [AW-1:0]                 tap_idx;
  logic signed [COEFF_WIDTH-1:0] h_sel;
  logic signed [DATA_WIDTH-1:0]  x_sel;
  logic signed [PROD_W-1:0]      prod;
  logic signed [ACC_W-1:0]       acc_sum;
  logic signed [EXT_W-1:0]       acc_ext;
  logic signed [EXT_W-1:0]       acc_shr;
  logic signed [DATA_WIDTH-1:0]  sat_val;

  assign idle   = (state_q == S_IDLE);
  assign accept = bus.in_valid && bus.in_ready;

  // ---------------------------------------------------------------------------
  // Datapath: one multiply-accumulate per ACCUM cycle
  // ---------------------------------------------------------------------------
  assign tap_idx = AW'(32'(k_q) * INTERP + 32'(phase_q));
  assign h_sel   = h_q[tap_idx];
  assign x_sel   = x_q[k_q];
  // Operands are widened first so the product is formed at full precision.
  assign prod    = PROD_W'(h_sel) * PROD_W'(x_sel);
  // acc_sum already contains the current product, so on the last ACCUM
  // cycle it is the complete dot product for this phase.
  assign acc_sum = acc_q + ACC_W'(prod);

`ifdef FIR_INTERP_ROUND_EN
  localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [EXT_W-1:0] RND_C =
    (SHIFT > 0) ? (EXT_W'(1) <<< RND_SH) : '0;
  assign acc_ext = EXT_W'(acc_sum) + RND_C;
`else
  assign acc_ext = EXT_W'(acc_sum);
`endif

  assign acc_shr = acc_ext >>> SHIFT;

  always_comb begin
    sat_val = acc_shr[DATA_WIDTH-1:0];
    if (acc_shr > SAT_MAX) begin
      sat_val = SAT_MAX[DATA_WIDTH-1:0];
    end else if (acc_shr < SAT_MIN) begin
      sat_val = SAT_MIN[DATA_WIDTH-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    k_d        = k_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_ACCUM;
          phase_d = '0;
          k_d     = '0;
          acc_d   = '0;
        end
      end
      S_ACCUM: begin
        acc_d = acc_sum;
        k_d   = k_q + KW'(1);
        if (k_q == KW'(K - 1)) begin
          state_d    = S_OUTPUT;
          out_data_d = sat_val;
          k_d        = '0;
        end
      end
      S_OUTPUT: begin
        if (bus.out_ready) begin
          k_d   = '0;
          acc_d = '0;
          if (phase_q == PW'(INTERP - 1)) begin
            state_d = S_IDLE;
            phase_d = '0;
          end else begin
            state_d = S_ACCUM;
            phase_d = phase_q + PW'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        phase_d = '0;
        k_d     = '0;
        acc_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      phase_q    <= '0;
      k_q        <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      k_q        <= k_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Sample delay line: shifts only when a new input is accepted, so it stays
  // frozen across all INTERP phases of that input.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < K; i++) begin
        x_q[i] <= '0;
      end
    end else if (accept) begin
      for (int i = 1; i < K; i++) begin
        x_q[i] <= x_q[i-1];
      end
      x_q[0] <= bus.in_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Coefficient bank. Writes land only while IDLE; a write issued in the same
  // cycle as an input acceptance is visible to that input's first product,
  // because ACCUM starts reading one edge later. Out-of-range addresses are
  // dropped silently; in-range writes while busy raise coef_err instead.
  // ---------------------------------------------------------------------------
  assign coef_hit = bus.coef_wr_en && (32'(bus.coef_addr) < NUM_TAPS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        h_q[i] <= '0;
      end
      coef_err_q <= 1'b0;
    end else begin
      coef_err_q <= coef_hit && !idle;
      if (coef_hit && idle) begin
        h_q[bus.coef_addr] <= bus.coef_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. in_ready is gated by rst so nothing is offered during reset.
  // ---------------------------------------------------------------------------
  assign bus.in_ready  = idle && !rst;
  assign bus.out_valid = (state_q == S_OUTPUT);
  assign bus.out_data  = out_data_q;
  assign bus.coef_err  = coef_err_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_fir_interp_poly.sv
// -----------------------------------------------------------------------------
// tb_fir_interp_poly
//   dut0: NUM_TAPS=4, INTERP=2, SHIFT=0 (impulse, same-cycle write,
//         backpressure, busy write, saturation, reset mid-ACCUM)
//   dut1: NUM_TAPS=6, INTERP=3, SHIFT=1 (rounding / truncation, address range)
//   A dot-product model predicts every output; directed literals pin it.
// -----------------------------------------------------------------------------
module tb_fir_interp_poly;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] state0, state1;
  always #5 clk = ~clk;

  fir_interp_poly_if #(.DATA_WIDTH(8), .COEFF_WIDTH(8), .NUM_TAPS(4)) if0 ();
  fir_interp_poly_if #(.DATA_WIDTH(8), .COEFF_WIDTH(8), .NUM_TAPS(6)) if1 ();

  fir_interp_poly #(.DATA_WIDTH(8), .COEFF_WIDTH(8), .NUM_TAPS(4),
                    .INTERP(2), .SHIFT(0)) dut0 (
    .clk(clk), .rst(rst), .bus(if0), .state_o(state0));

  fir_interp_poly #(.DATA_WIDTH(8), .COEFF_WIDTH(8), .NUM_TAPS(6),
                    .INTERP(3), .SHIFT(1)) dut1 (
    .clk(clk), .rst(rst), .bus(if1), .state_o(state1));

  // ---------------------------------------------------------------- bookkeeping
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(string name, int got, int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic fail_now(string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: event did not occur, expected it to", name);
  endtask

  // ---------------------------------------------------------------- model
  int h_m [2][6];
  int x_m [2][3];
  logic [7:0] exp_q0[$], exp_q1[$];
  logic [7:0] got_q0[$], got_q1[$];

  function automatic int taps_of(int sel);  return (sel == 0) ? 4 : 6; endfunction
  function automatic int interp_of(int sel); return (sel == 0) ? 2 : 3; endfunction
  function automatic int shift_of(int sel);  return (sel == 0) ? 0 : 1; endfunction

  // y_p = sat((sum_k h[k*L+p] * x[k] (+ 2^(S-1))) >>> S)
  function automatic int model_out(int sel, int p);
    int l = interp_of(sel);
    int kk = taps_of(sel) / l;
    longint acc = 0;
    for (int k = 0; k < kk; k++) begin
      acc += longint'(h_m[sel][k*l+p]) * longint'(x_m[sel][k]);
    end
    if (shift_of(sel) > 0) begin
`ifdef FIR_INTERP_ROUND_EN
      acc += longint'(1) << (shift_of(sel) - 1);
`endif
      acc = acc >>> shift_of(sel);
    end
    if (acc > 127)  acc = 127;
    if (acc < -128) acc = -128;
    return int'(acc);
  endfunction

  function automatic void model_accept(int sel, int sample);
    int kk = taps_of(sel) / interp_of(sel);
    for (int k = kk - 1; k > 0; k--) x_m[sel][k] = x_m[sel][k-1];
    x_m[sel][0] = sample;
    for (int p = 0; p < interp_of(sel); p++) begin
      if (sel == 0) exp_q0.push_back(8'(model_out(sel, p)));
      else          exp_q1.push_back(8'(model_out(sel, p)));
    end
  endfunction

  function automatic void model_write(int sel, int addr, int data);
    if (addr < taps_of(sel)) h_m[sel][addr] = data;
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 6; i++) h_m[s][i] = 0;
      for (int i = 0; i < 3; i++) x_m[s][i] = 0;
    end
    exp_q0.delete(); exp_q1.delete();
    got_q0.delete(); got_q1.delete();
  endfunction

  // ---------------------------------------------------------------- compare
  logic       hold0 = 1'b0, hold1 = 1'b0;
  logic [7:0] hold_d0, hold_d1, e;

  always @(negedge clk) begin
    if (rst) begin
      hold0 = 1'b0;
      hold1 = 1'b0;
    end else begin
      if (hold0) begin
        check("hold_valid0", int'(if0.out_valid), 1);
        check("hold_data0", $signed(if0.out_data), $signed(hold_d0));
      end
      if (if0.out_valid) begin
        check("in_ready_busy0", int'(if0.in_ready), 0);
        if (if0.out_ready) begin
          if (exp_q0.size() == 0) fail_now("unexpected_out0");
          else begin
            e = exp_q0.pop_front();
            check("out0", $signed(if0.out_data), $signed(e));
          end
          got_q0.push_back(if0.out_data);
        end
      end
      hold0   = if0.out_valid && !if0.out_ready;
      hold_d0 = if0.out_data;

      if (hold1) begin
        check("hold_valid1", int'(if1.out_valid), 1);
        check("hold_data1", $signed(if1.out_data), $signed(hold_d1));
      end
      if (if1.out_valid) begin
        check("in_ready_busy1", int'(if1.in_ready), 0);
        if (if1.out_ready) begin
          if (exp_q1.size() == 0) fail_now("unexpected_out1");
          else begin
            e = exp_q1.pop_front();
            check("out1", $signed(if1.out_data), $signed(e));
          end
          got_q1.push_back(if1.out_data);
        end
      end
      hold1   = if1.out_valid && !if1.out_ready;
      hold_d1 = if1.out_data;
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdy(int sel);
    return (sel == 0) ? if0.in_ready : if1.in_ready;
  endfunction

  function automatic logic ovld(int sel);
    return (sel == 0) ? if0.out_valid : if1.out_valid;
  endfunction

  function automatic logic cerr(int sel);
    return (sel == 0) ? if0.coef_err : if1.coef_err;
  endfunction

  function automatic int qsize(int sel);
    return (sel == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  task automatic set_in(int sel, logic v, int d);
    if (sel == 0) begin if0.in_valid = v; if0.in_data = 8'(d); end
    else          begin if1.in_valid = v; if1.in_data = 8'(d); end
  endtask

  task automatic set_wr(int sel, logic en, int addr, int data);
    if (sel == 0) begin
      if0.coef_wr_en = en; if0.coef_addr = 2'(addr); if0.coef_data = 8'(data);
    end else begin
      if1.coef_wr_en = en; if1.coef_addr = 3'(addr); if1.coef_data = 8'(data);
    end
  endtask

  task automatic set_ordy(int sel, logic r);
    if (sel == 0) if0.out_ready = r;
    else          if1.out_ready = r;
  endtask

  // Call only while the DUT is idle.
  task automatic write_coef(int sel, int addr, int data);
    set_wr(sel, 1'b1, addr, data);
    tick();
    set_wr(sel, 1'b0, 0, 0);
    model_write(sel, addr, data);
    @(negedge clk);
    check("coef_err_idle", int'(cerr(sel)), 0);
    tick();
  endtask

  // Optional coefficient write in the acceptance cycle (DUT must be idle).
  task automatic send(int sel, int sample, bit do_wr, int addr, int data);
    bit ok = 1'b0;
    set_in(sel, 1'b1, sample);
    if (do_wr) set_wr(sel, 1'b1, addr, data);
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = rdy(sel);
      tick();
    end
    set_in(sel, 1'b0, 0);
    set_wr(sel, 1'b0, 0, 0);
    if (!ok) fail_now("accept_timeout");
    else begin
      if (do_wr) model_write(sel, addr, data);
      model_accept(sel, sample);
    end
  endtask

  task automatic wait_idle(int sel);
    bit ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      ok = rdy(sel) && (qsize(sel) == 0);
    end
    if (!ok) fail_now("idle_timeout");
    tick();
  endtask

  // Cycles counted from the acceptance cycle (cycle 0) to first out_valid.
  task automatic check_latency(int sel, int exp, string name);
    int n = 0;
    bit seen = 1'b0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(negedge clk);
      if (ovld(sel)) begin seen = 1'b1; n = c; end
    end
    check(name, n, exp);
  endtask

  task automatic check_got(int sel, int idx, int exp, string name);
    int sz = (sel == 0) ? got_q0.size() : got_q1.size();
    if (idx >= sz) fail_now(name);
    else if (sel == 0) check(name, $signed(got_q0[idx]), exp);
    else               check(name, $signed(got_q1[idx]), exp);
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    n_errors++;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    bit seen;
    model_reset();
    set_in(0, 1'b0, 0); set_in(1, 1'b0, 0);
    set_wr(0, 1'b0, 0, 0); set_wr(1, 1'b0, 0, 0);
    set_ordy(0, 1'b1); set_ordy(1, 1'b1);

    // Reset state
    @(negedge clk);
    check("rst_in_ready0", int'(if0.in_ready), 0);
    check("rst_out_valid0", int'(if0.out_valid), 0);
    check("rst_out_data0", $signed(if0.out_data), 0);
    check("rst_coef_err0", int'(if0.coef_err), 0);
    check("rst_in_ready1", int'(if1.in_ready), 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst0", int'(if0.in_ready), 1);
    check("in_ready_after_rst1", int'(if1.in_ready), 1);
    tick();

    // Impulse: h={3,5,7,9}, inputs 1,0,0 -> 3,5,7,9,0,0
    write_coef(0, 0, 3); write_coef(0, 1, 5);
    write_coef(0, 2, 7); write_coef(0, 3, 9);
    got_q0.delete();
    send(0, 1, 1'b0, 0, 0);
    check_latency(0, 3, "latency0");
    wait_idle(0);
    send(0, 0, 1'b0, 0, 0); wait_idle(0);
    send(0, 0, 1'b0, 0, 0); wait_idle(0);
    check_got(0, 0, 3, "imp_0"); check_got(0, 1, 5, "imp_1");
    check_got(0, 2, 7, "imp_2"); check_got(0, 3, 9, "imp_3");
    check_got(0, 4, 0, "imp_4"); check_got(0, 5, 0, "imp_5");

    // Write in the acceptance cycle: h0=-4 used at once, x=[2,0] -> -8,10
    got_q0.delete();
    send(0, 2, 1'b1, 0, -4); wait_idle(0);
    check_got(0, 0, -8, "samecyc_0"); check_got(0, 1, 10, "samecyc_1");
    write_coef(0, 0, 3);

    // Backpressure: x=[3,2] -> 23,33 with 5 stalled cycles on phase 0
    got_q0.delete();
    set_ordy(0, 1'b0);
    send(0, 3, 1'b0, 0, 0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = if0.out_valid;
    end
    if (!seen) fail_now("bp_valid_timeout");
    tick();
    repeat (5) tick();
    set_ordy(0, 1'b1);
    wait_idle(0);
    check("bp_count", got_q0.size(), 2);
    check_got(0, 0, 23, "bp_0"); check_got(0, 1, 33, "bp_1");

    // Busy write: dropped, coef_err one cycle; x=[1,3] -> 24,32
    got_q0.delete();
    send(0, 1, 1'b0, 0, 0);
    set_wr(0, 1'b1, 1, 100);
    tick();
    set_wr(0, 1'b0, 0, 0);
    @(negedge clk);
    check("busy_coef_err_hi", int'(if0.coef_err), 1);
    @(negedge clk);
    check("busy_coef_err_lo", int'(if0.coef_err), 0);
    wait_idle(0);
    check_got(0, 0, 24, "busy_0"); check_got(0, 1, 32, "busy_1");

    // Saturation: all h=127; 127 -> 127,127; -128,-128 -> ... -128,-128
    for (int i = 0; i < 4; i++) write_coef(0, i, 127);
    got_q0.delete();
    send(0, 127, 1'b0, 0, 0); wait_idle(0);
    send(0, -128, 1'b0, 0, 0); wait_idle(0);
    send(0, -128, 1'b0, 0, 0); wait_idle(0);
    check_got(0, 0, 127, "sat_hi_0"); check_got(0, 1, 127, "sat_hi_1");
    check_got(0, 4, -128, "sat_lo_0"); check_got(0, 5, -128, "sat_lo_1");

    // Reset mid-ACCUM, then the impulse sequence gives all zeros
    send(0, 5, 1'b0, 0, 0);
    tick();
    rst = 1'b1;
    #1;
    check("midrst_out_valid", int'(if0.out_valid), 0);
    check("midrst_in_ready", int'(if0.in_ready), 0);
    check("midrst_out_data", $signed(if0.out_data), 0);
    model_reset();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_in_ready_after", int'(if0.in_ready), 1);
    tick();
    send(0, 1, 1'b0, 0, 0); wait_idle(0);
    send(0, 0, 1'b0, 0, 0); wait_idle(0);
    send(0, 0, 1'b0, 0, 0); wait_idle(0);
    check("zero_count", got_q0.size(), 6);
    for (int i = 0; i < 6; i++) check_got(0, i, 0, "zero_out");

    // dut1: SHIFT=1 rounding, accumulators 3, -3, 1
    write_coef(1, 0, 3); write_coef(1, 1, -3); write_coef(1, 2, 1);
    write_coef(1, 6, 50); write_coef(1, 7, -50);
    got_q1.delete();
    send(1, 1, 1'b0, 0, 0);
    check_latency(1, 3, "latency1");
    wait_idle(1);
`ifdef FIR_INTERP_ROUND_EN
    check_got(1, 0, 2, "round_p0"); check_got(1, 1, -1, "round_p1");
    check_got(1, 2, 1, "round_p2");
`else
    check_got(1, 0, 1, "trunc_p0"); check_got(1, 1, -2, "trunc_p1");
    check_got(1, 2, 0, "trunc_p2");
`endif
    write_coef(1, 3, 10); write_coef(1, 4, -7); write_coef(1, 5, 2);
    send(1, 2, 1'b0, 0, 0); wait_idle(1);
    send(1, 0, 1'b0, 0, 0); wait_idle(1);
    check("dut1_count", got_q1.size(), 9);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
